// File: rtl/noc_output_arbiter_pkg.sv
// Shared definitions for the NoC output arbiter: default flit width and FSM state encoding.
// Also provides the round-robin index helper used by noc_rr_pick.
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

package noc_output_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // Port index reached by stepping 'step' places past 'base', wrapping at 'n'.
    function automatic int unsigned rr_index(input int unsigned base,
                                             input int unsigned step,
                                             input int unsigned n);
        return (base + step) % n;
    endfunction

endpackage

// File: rtl/noc_rr_pick.sv
// Combinational round-robin picker: first requester found searching from i_last_ptr+1 upward, wrapping.
module noc_rr_pick
    import noc_output_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned PTR_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [PTR_W-1:0]     i_last_ptr,
    output logic [PTR_W-1:0]     o_winner,
    output logic                 o_any_req
);

    // Walk the search order backwards so the nearest requester is the one left standing.
    always_comb begin
        o_winner  = '0;
        o_any_req = 1'b0;
        for (int unsigned k = NUM_PORTS; k >= 1; k--) begin
            int unsigned w_idx;
            w_idx = rr_index(32'(i_last_ptr), k, NUM_PORTS);
            if (i_req[PTR_W'(w_idx)]) begin
                o_winner  = PTR_W'(w_idx);
                o_any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/noc_output_arbiter.sv
// Wormhole round-robin arbiter sharing one NoC output link between NUM_PORTS requesters.
// Optional per-port tail counters are enabled by defining NOC_ARB_PKT_CNT_EN.
module noc_output_arbiter
    import noc_output_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = 4,
    parameter int unsigned DATA_WIDTH = `Noc_Data_Width
) (
    input  logic                            noc_clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            in_valid,
    output logic [NUM_PORTS-1:0]            in_ready,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_flit,
    input  logic [NUM_PORTS-1:0]            in_is_header,
    input  logic [NUM_PORTS-1:0]            in_is_tail,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_WIDTH-1:0]           out_flit,
    output logic                            out_is_header,
    output logic                            out_is_tail,
    output logic [NUM_PORTS-1:0]            grant,
    output logic                            busy
`ifdef NOC_ARB_PKT_CNT_EN
    ,
    output logic [32*NUM_PORTS-1:0]         pkt_cnt
`endif
);

    localparam int unsigned PTR_W = $clog2(NUM_PORTS);

    arb_state_t           r_state;
    logic [PTR_W-1:0]     r_owner;
    logic [PTR_W-1:0]     r_last_ptr;
    logic [NUM_PORTS-1:0] r_grant;

    logic [NUM_PORTS-1:0] w_req;
    logic [PTR_W-1:0]     w_winner;
    logic                 w_any_req;
    logic                 w_xfer;
    logic                 w_tail_xfer;

    assign w_req = in_valid & in_is_header;

    noc_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PTR_W     (PTR_W)
    ) u_pick (
        .i_req      (w_req),
        .i_last_ptr (r_last_ptr),
        .o_winner   (w_winner),
        .o_any_req  (w_any_req)
    );

    // Owner's flit passes straight through; nothing moves while idle.
    always_comb begin
        in_ready      = '0;
        out_valid     = 1'b0;
        out_flit      = '0;
        out_is_header = 1'b0;
        out_is_tail   = 1'b0;
        if (r_state == ARB_LOCKED) begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                if (r_owner == PTR_W'(i)) begin
                    out_valid     = in_valid[i];
                    out_flit      = in_flit[i*DATA_WIDTH +: DATA_WIDTH];
                    out_is_header = in_is_header[i];
                    out_is_tail   = in_is_tail[i];
                    in_ready[i]   = out_ready;
                end
            end
        end
    end

    assign w_xfer      = out_valid && out_ready;
    assign w_tail_xfer = w_xfer && out_is_tail;

    // Arbitration FSM: pick on a header, hold until the owner's tail moves.
    always_ff @(posedge noc_clk) begin
        if (rst) begin
            r_state    <= ARB_IDLE;
            r_owner    <= '0;
            r_last_ptr <= PTR_W'(NUM_PORTS - 1);
            r_grant    <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_any_req) begin
                        r_state <= ARB_LOCKED;
                        r_owner <= w_winner;
                        r_grant <= NUM_PORTS'(1) << w_winner;
                    end
                end
                ARB_LOCKED: begin
                    if (w_tail_xfer) begin
                        r_state    <= ARB_IDLE;
                        r_last_ptr <= r_owner;
                        r_grant    <= '0;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    assign grant = r_grant;
    assign busy  = (r_state == ARB_LOCKED);

`ifdef NOC_ARB_PKT_CNT_EN
    logic [31:0] r_pkt_cnt [NUM_PORTS];

    // Completed-packet count per port, free-running with natural 32-bit wrap.
    always_ff @(posedge noc_clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                r_pkt_cnt[i] <= '0;
            end
        end else if (w_tail_xfer) begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                if (r_owner == PTR_W'(i)) begin
                    r_pkt_cnt[i] <= r_pkt_cnt[i] + 32'd1;
                end
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            pkt_cnt[i*32 +: 32] = r_pkt_cnt[i];
        end
    end
`endif

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Self-checking bench for noc_output_arbiter: directed scenarios plus randomized traffic vs. a packet-level model.
module tb_noc_output_arbiter;

    localparam int NP = 4;
    localparam int DW = 32;

    logic              noc_clk = 1'b0;
    logic              rst;
    logic [NP-1:0]     in_valid, in_ready, in_is_header, in_is_tail, grant;
    logic [NP*DW-1:0]  in_flit;
    logic              out_valid, out_ready, out_is_header, out_is_tail, busy;
    logic [DW-1:0]     out_flit;
`ifdef NOC_ARB_PKT_CNT_EN
    logic [32*NP-1:0]  pkt_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;

    // Per-port packet source state.
    int plen  [NP];
    int fidx  [NP];
    int pktno [NP];
    int npkts [NP];
    bit shown [NP];
    int gap_pct;
    bit rand_len;

    always #5 noc_clk = ~noc_clk;

    noc_output_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) dut (
        .noc_clk       (noc_clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_flit       (in_flit),
        .in_is_header  (in_is_header),
        .in_is_tail    (in_is_tail),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_flit      (out_flit),
        .out_is_header (out_is_header),
        .out_is_tail   (out_is_tail),
        .grant         (grant),
        .busy          (busy)
`ifdef NOC_ARB_PKT_CNT_EN
        ,
        .pkt_cnt       (pkt_cnt)
`endif
    );

    function automatic logic [DW-1:0] flit_val(input int p, input int pk, input int f);
        return {8'(p), 8'(pk), 16'(f)};
    endfunction

    task automatic clear_driver();
        for (int p = 0; p < NP; p++) begin
            plen[p] = 1; fidx[p] = 0; pktno[p] = 0; npkts[p] = 0; shown[p] = 1'b0;
        end
        gap_pct = 0; rand_len = 1'b0;
        in_valid = '0; in_is_header = '0; in_is_tail = '0; in_flit = '0;
    endtask

    // Present each port's current flit; once shown, a flit stays valid until accepted.
    task automatic drive_inputs();
        for (int p = 0; p < NP; p++) begin
            bit v;
            v = (npkts[p] > 0) && (shown[p] || (int'($urandom_range(99)) >= gap_pct));
            in_valid[p]     = v;
            in_is_header[p] = v && (fidx[p] == 0);
            in_is_tail[p]   = v && (fidx[p] == plen[p] - 1);
            in_flit[p*DW +: DW] = v ? flit_val(p, pktno[p], fidx[p]) : '0;
            shown[p] = v;
        end
    endtask

    task automatic finish_cycle();
        logic [NP-1:0] acc;
        acc = in_valid & in_ready;
        @(posedge noc_clk);
        #1;
        cyc++;
        for (int p = 0; p < NP; p++) begin
            if (acc[p]) begin
                shown[p] = 1'b0;
                fidx[p]++;
                if (fidx[p] == plen[p]) begin
                    fidx[p] = 0; pktno[p]++; npkts[p]--;
                    if (rand_len) plen[p] = int'($urandom_range(1, 4));
                end
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_driver();
        repeat (2) @(posedge noc_clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        do_reset();
        out_ready = 1'b1;
        for (int p = 0; p < NP; p++) npkts[p] = 1;
        drive_inputs(); #1;
        n_checks++;
        if ({grant, busy, in_ready, out_valid} !== '0) begin
            n_fail++;
            $display("FAIL reset_idle: grant=%b busy=%b in_ready=%b out_valid=%b, want all 0",
                     grant, busy, in_ready, out_valid);
        end
        finish_cycle();
        drive_inputs(); #1;
        n_checks++;
        if (grant !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_first_winner: grant=%b want 0001", grant);
        end
    endtask

    task automatic test_single_port();
        logic [NP-1:0] eg, er;
        do_reset();
        out_ready = 1'b1;
        npkts[2] = 1; plen[2] = 3;
        for (int c = 0; c < 5; c++) begin
            drive_inputs(); #1;
            n_checks++;
            if (c >= 1 && c <= 3) begin
                eg = 4'b0100; er = 4'b0100;
                if ({grant, busy, out_valid, in_ready} !== {eg, 1'b1, 1'b1, er} ||
                    out_flit !== flit_val(2, 0, c - 1) ||
                    out_is_header !== (c == 1) || out_is_tail !== (c == 3)) begin
                    n_fail++;
                    $display("FAIL single_port c%0d: grant=%b busy=%b ov=%b rdy=%b flit=%h h=%b t=%b want grant=0100 flit=%h",
                             c, grant, busy, out_valid, in_ready, out_flit, out_is_header, out_is_tail, flit_val(2, 0, c - 1));
                end
            end else if ({grant, busy, out_valid, in_ready} !== '0) begin
                n_fail++;
                $display("FAIL single_port_idle c%0d: grant=%b busy=%b ov=%b rdy=%b want all 0",
                         c, grant, busy, out_valid, in_ready);
            end
            finish_cycle();
        end
    endtask

    task automatic test_contest();
        int lc[$];
        logic [DW-1:0] lf[$];
        int exp_c[6] = '{1, 2, 4, 5, 7, 8};
        int exp_p[6] = '{0, 0, 1, 1, 3, 3};
        do_reset();
        out_ready = 1'b1;
        npkts[0] = 1; npkts[1] = 1; npkts[3] = 1;
        plen[0] = 2; plen[1] = 2; plen[3] = 2;
        for (int c = 0; c < 12; c++) begin
            drive_inputs(); #1;
            if (out_valid && out_ready) begin lc.push_back(cyc); lf.push_back(out_flit); end
            finish_cycle();
        end
        n_checks++;
        if (lc.size() != 6) begin
            n_fail++;
            $display("FAIL contest_count: transfers=%0d want 6", lc.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (lc[i] != exp_c[i] || lf[i] !== flit_val(exp_p[i], 0, i % 2)) begin
                    n_fail++;
                    $display("FAIL contest_order #%0d: cycle=%0d flit=%h want cycle=%0d flit=%h",
                             i, lc[i], lf[i], exp_c[i], flit_val(exp_p[i], 0, i % 2));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int lc[$];
        logic [DW-1:0] lf[$];
        bit rdy[8] = '{1, 1, 0, 0, 0, 1, 1, 1};
        int exp_c[3] = '{1, 5, 6};
        do_reset();
        npkts[1] = 1; plen[1] = 3;
        for (int c = 0; c < 8; c++) begin
            out_ready = rdy[c];
            drive_inputs(); #1;
            if (c >= 2 && c <= 4) begin
                n_checks++;
                if (out_valid !== 1'b1 || in_ready !== 4'b0000 || out_flit !== flit_val(1, 0, 1)) begin
                    n_fail++;
                    $display("FAIL backpressure_hold c%0d: ov=%b rdy=%b flit=%h want ov=1 rdy=0000 flit=%h",
                             c, out_valid, in_ready, out_flit, flit_val(1, 0, 1));
                end
            end
            if (out_valid && out_ready) begin lc.push_back(cyc); lf.push_back(out_flit); end
            finish_cycle();
        end
        n_checks++;
        if (lc.size() != 3) begin
            n_fail++;
            $display("FAIL backpressure_count: transfers=%0d want 3", lc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (lc[i] != exp_c[i] || lf[i] !== flit_val(1, 0, i)) begin
                    n_fail++;
                    $display("FAIL backpressure_flit #%0d: cycle=%0d flit=%h want cycle=%0d flit=%h",
                             i, lc[i], lf[i], exp_c[i], flit_val(1, 0, i));
                end
            end
        end
    endtask

    task automatic test_single_flit();
        do_reset();
        out_ready = 1'b1;
        npkts[3] = 1; plen[3] = 1;
        drive_inputs(); #1;
        finish_cycle();
        drive_inputs(); #1;
        n_checks++;
        if ({grant, out_valid, out_is_header, out_is_tail, in_ready} !== {4'b1000, 3'b111, 4'b1000}) begin
            n_fail++;
            $display("FAIL single_flit_xfer: grant=%b ov=%b h=%b t=%b rdy=%b want 1000 1 1 1 1000",
                     grant, out_valid, out_is_header, out_is_tail, in_ready);
        end
        finish_cycle();
        npkts[0] = 1; plen[0] = 1; npkts[3] = 1;
        drive_inputs(); #1;
        n_checks++;
        if (grant !== 4'b0000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_flit_release: grant=%b busy=%b want 0000 0", grant, busy);
        end
        finish_cycle();
        drive_inputs(); #1;
        n_checks++;
        if (grant !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_flit_rotate: grant=%b want 0001", grant);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b1;
        npkts[2] = 1; plen[2] = 4;
        drive_inputs(); #1; finish_cycle();
        drive_inputs(); #1; finish_cycle();
        drive_inputs(); rst = 1'b1; #1; finish_cycle();
        rst = 1'b0;
        clear_driver();
        npkts[0] = 1; plen[0] = 2;
        drive_inputs(); #1;
        n_checks++;
        if ({grant, busy, in_ready, out_valid} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_abort: grant=%b busy=%b rdy=%b ov=%b want all 0",
                     grant, busy, in_ready, out_valid);
        end
        finish_cycle();
        drive_inputs(); #1;
        n_checks++;
        if (grant !== 4'b0001 || out_valid !== 1'b1 || out_flit !== flit_val(0, 0, 0)) begin
            n_fail++;
            $display("FAIL reset_mid_regrant: grant=%b ov=%b flit=%h want 0001 1 %h",
                     grant, out_valid, out_flit, flit_val(0, 0, 0));
        end
    endtask

    // Packet-level model: idle picks the first header after the last finisher; locked follows the owner.
    task automatic test_random();
        bit m_locked = 1'b0;
        int m_owner = 0;
        int m_last = NP - 1;
        int pending;
        logic [NP-1:0] eg, er;
        logic ev;
        do_reset();
        rand_len = 1'b1; gap_pct = 30;
        for (int p = 0; p < NP; p++) begin
            npkts[p] = int'($urandom_range(3, 6));
            plen[p]  = int'($urandom_range(1, 4));
        end
        for (int c = 0; c < 4000; c++) begin
            pending = 0;
            for (int p = 0; p < NP; p++) pending += npkts[p];
            if (pending == 0) break;
            out_ready = ($urandom_range(3) != 0);
            drive_inputs(); #1;
            eg = '0; er = '0; ev = 1'b0;
            if (m_locked) begin
                eg[m_owner] = 1'b1;
                ev = in_valid[m_owner];
                er[m_owner] = out_ready;
            end
            n_checks++;
            if ({grant, busy, out_valid, in_ready} !== {eg, m_locked, ev, er}) begin
                n_fail++;
                $display("FAIL random_ctrl c%0d: grant=%b busy=%b ov=%b rdy=%b want %b %b %b %b",
                         c, grant, busy, out_valid, in_ready, eg, m_locked, ev, er);
            end
            if (ev) begin
                n_checks++;
                if (out_flit !== flit_val(m_owner, pktno[m_owner], fidx[m_owner]) ||
                    out_is_header !== (fidx[m_owner] == 0) ||
                    out_is_tail !== (fidx[m_owner] == plen[m_owner] - 1)) begin
                    n_fail++;
                    $display("FAIL random_flit c%0d: flit=%h h=%b t=%b want %h",
                             c, out_flit, out_is_header, out_is_tail,
                             flit_val(m_owner, pktno[m_owner], fidx[m_owner]));
                end
            end
            if (m_locked) begin
                if (ev && out_ready && fidx[m_owner] == plen[m_owner] - 1) begin
                    m_locked = 1'b0;
                    m_last = m_owner;
                end
            end else begin
                for (int k = 1; k <= NP; k++) begin
                    int q;
                    q = (m_last + k) % NP;
                    if (in_valid[q] && in_is_header[q]) begin
                        m_locked = 1'b1;
                        m_owner = q;
                        break;
                    end
                end
            end
            finish_cycle();
        end
        pending = 0;
        for (int p = 0; p < NP; p++) pending += npkts[p];
        n_checks++;
        if (pending != 0) begin
            n_fail++;
            $display("FAIL random_drain: %0d packets still pending, want 0", pending);
        end
    endtask

`ifdef NOC_ARB_PKT_CNT_EN
    task automatic test_pkt_cnt();
        logic [32*NP-1:0] exp_cnt;
        do_reset();
        out_ready = 1'b1;
        npkts[2] = 5; plen[2] = 2;
        for (int c = 0; c < 100 && npkts[2] > 0; c++) begin
            drive_inputs(); #1;
            finish_cycle();
        end
        exp_cnt = '0;
        exp_cnt[2*32 +: 32] = 32'd5;
        n_checks++;
        if (pkt_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL pkt_cnt: got %h want %h", pkt_cnt, exp_cnt);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        clear_driver();
        test_reset();
        test_single_port();
        test_contest();
        test_backpressure();
        test_single_flit();
        test_reset_mid();
        test_random();
`ifdef NOC_ARB_PKT_CNT_EN
        test_pkt_cnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
